// File: rtl/spi_arbiter_if.sv
// rtl/spi_arbiter_if.sv - requester and spi_M side signals of spi_arbiter
// slave: the arbiter's view; master: the environment's view (requesters plus spi_M).
interface spi_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [7:0]        rsp_data;
  logic              busy;
  logic              m_start;
  logic [7:0]        m_din;
  logic [7:0]        m_dout;
  logic              m_done;
  logic              timeout_err;

  modport slave (
    input  req, req_data, m_dout, m_done,
    output gnt, rsp_valid, rsp_data, busy, m_start, m_din, timeout_err
  );

  modport master (
    output req, req_data, m_dout, m_done,
    input  gnt, rsp_valid, rsp_data, busy, m_start, m_din, timeout_err
  );
endinterface

// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - round-robin arbiter sharing one spi_M among NREQ requesters
// Define SPI_ARB_TIMEOUT_EN to compile in the WAIT timeout (rsp_data=8'hFF, timeout_err pulse).
module spi_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input logic         clk,
  input logic         rst,
  spi_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic [7:0]      m_din_q, m_din_d;
  logic            m_start_q, m_start_d;
  logic            busy_q, busy_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [PW-1:0]   arb_idx;
  logic            arb_found;
`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0]     cnt_q, cnt_d;
  logic            terr_q, terr_d;
`endif

  // First set req bit at or above ptr, wrapping past NREQ-1 back to 0.
  always_comb begin
    arb_idx   = '0;
    arb_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!arb_found && bus.req[(int'(ptr_q) + i) % NREQ]) begin
        arb_found = 1'b1;
        arb_idx   = PW'((int'(ptr_q) + i) % NREQ);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    m_din_d     = m_din_q;
    m_start_d   = 1'b0;
    ptr_d       = ptr_q;
    win_d       = win_q;
`ifdef SPI_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    terr_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          win_d          = arb_idx;
          gnt_d          = '0;
          gnt_d[arb_idx] = 1'b1;
          m_din_d        = bus.req_data[8*int'(arb_idx) +: 8];
          state_d        = START;
        end
      end
      START: begin
        m_start_d = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
        cnt_d     = '0;
`endif
        state_d   = WAIT;
      end
      WAIT: begin
        if (bus.m_done) begin
          rsp_data_d         = bus.m_dout;
          gnt_d              = '0;
          rsp_valid_d[win_q] = 1'b1;
          state_d            = RESP;
`ifdef SPI_ARB_TIMEOUT_EN
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          rsp_data_d         = 8'hFF;
          terr_d             = 1'b1;
          gnt_d              = '0;
          rsp_valid_d[win_q] = 1'b1;
          state_d            = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
`endif
        end
      end
      RESP: begin
        ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= 8'h00;
      m_din_q     <= 8'h00;
      m_start_q   <= 1'b0;
      busy_q      <= 1'b0;
      ptr_q       <= '0;
      win_q       <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      terr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      m_din_q     <= m_din_d;
      m_start_q   <= m_start_d;
      busy_q      <= busy_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      terr_q      <= terr_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.m_din     = m_din_q;
  assign bus.m_start   = m_start_q;
  assign bus.busy      = busy_q;
`ifdef SPI_ARB_TIMEOUT_EN
  assign bus.timeout_err = terr_q;
`else
  assign bus.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - directed self-checking bench for spi_arbiter (NREQ=4, TIMEOUT=16)
module tb_spi_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  spi_arbiter_if #(.NREQ(4)) bus ();

  spi_arbiter #(.NREQ(4), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in IDLE with req already driven; returns one cycle into the following IDLE.
  task automatic txn(input int w, input logic [7:0] din, input logic [7:0] dout, input bit drop);
    step();
    check("gnt_start", 32'(bus.gnt), 32'(1 << w));
    check("busy_start", 32'(bus.busy), 1);
    check("mstart_early", 32'(bus.m_start), 0);
    step();
    check("mstart", 32'(bus.m_start), 1);
    check("mdin", 32'(bus.m_din), 32'(din));
    if (drop) bus.req = '0;
    step();
    check("mstart_once", 32'(bus.m_start), 0);
    check("gnt_wait", 32'(bus.gnt), 32'(1 << w));
    bus.m_dout = dout;
    bus.m_done = 1'b1;
    step();
    bus.m_done = 1'b0;
    check("rsp_valid", 32'(bus.rsp_valid), 32'(1 << w));
    check("rsp_data", 32'(bus.rsp_data), 32'(dout));
    check("gnt_resp", 32'(bus.gnt), 0);
    check("busy_resp", 32'(bus.busy), 1);
    step();
    check("rsp_valid_idle", 32'(bus.rsp_valid), 0);
    check("busy_idle", 32'(bus.busy), 0);
    check("gnt_idle", 32'(bus.gnt), 0);
    check("mdin_hold", 32'(bus.m_din), 32'(din));
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic timeout_run(input bit done_last);
    bus.req = 4'b0001;
    step();
    bus.req = '0;
    check("to_gnt", 32'(bus.gnt), 1);
    step();
    check("to_mstart", 32'(bus.m_start), 1);
    repeat (15) begin
      step();
      check("to_busy", 32'(bus.busy), 1);
      check("to_no_rsp", 32'(bus.rsp_valid), 0);
      check("to_no_err", 32'(bus.timeout_err), 0);
    end
    if (done_last) begin
      bus.m_dout = 8'h5A;
      bus.m_done = 1'b1;
    end
    step();
    bus.m_done = 1'b0;
    check("to_rsp_valid", 32'(bus.rsp_valid), 1);
    check("to_err", 32'(bus.timeout_err), done_last ? 0 : 1);
    check("to_rsp_data", 32'(bus.rsp_data), done_last ? 32'h5A : 32'hFF);
    step();
    check("to_err_clear", 32'(bus.timeout_err), 0);
    check("to_idle", 32'(bus.busy), 0);
  endtask
`endif

  initial begin
    rst         = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    bus.m_done   = 1'b0;
    bus.m_dout   = '0;
    step();
    step();
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_data", 32'(bus.rsp_data), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_mstart", 32'(bus.m_start), 0);
    check("rst_mdin", 32'(bus.m_din), 0);
    check("rst_terr", 32'(bus.timeout_err), 0);
    rst = 1'b1;
    step();

    // Basic transaction; owner drops req during WAIT.
    bus.req      = 4'b0001;
    bus.req_data = 32'h0000_00A5;
    txn(0, 8'hA5, 8'h3C, 1'b1);
    // m_done in IDLE is ignored.
    bus.m_dout = 8'h77;
    bus.m_done = 1'b1;
    step();
    bus.m_done = 1'b0;
    check("idle_done_rsp", 32'(bus.rsp_valid), 0);
    check("idle_done_busy", 32'(bus.busy), 0);
    step();
    check("idle_done_rsp2", 32'(bus.rsp_valid), 0);
    check("idle_done_data", 32'(bus.rsp_data), 32'h3C);

    // All four held: 0,1,2,3,0 from ptr=0.
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    bus.req      = 4'b1111;
    bus.req_data = 32'h4433_2211;
    for (int k = 0; k < 5; k++) begin
      txn(k % 4, 8'(8'h11 * ((k % 4) + 1)), 8'(8'hC0 + k), 1'b0);
    end
    bus.req = '0;

    // ptr=1 -> grant 1 -> ptr=2, then 0011 wraps to 0.
    bus.req = 4'b0010;
    txn(1, 8'h22, 8'h01, 1'b0);
    bus.req = 4'b0011;
    txn(0, 8'h11, 8'h02, 1'b0);

    // Single requester granted repeatedly.
    bus.req = 4'b1000;
    txn(3, 8'h44, 8'h03, 1'b0);
    txn(3, 8'h44, 8'h04, 1'b0);

    // Move ptr to 3, then reset during WAIT.
    bus.req = 4'b0100;
    txn(2, 8'h33, 8'h05, 1'b0);
    bus.req = 4'b1001;
    step();
    check("pre_rst_gnt", 32'(bus.gnt), 32'b1000);
    step();
    step();
    rst = 1'b0;
    #1;
    check("arst_gnt", 32'(bus.gnt), 0);
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_mdin", 32'(bus.m_din), 0);
    check("arst_mstart", 32'(bus.m_start), 0);
    check("arst_rsp_data", 32'(bus.rsp_data), 0);
    step();
    check("arst_rsp_valid", 32'(bus.rsp_valid), 0);
    rst = 1'b1;
    txn(0, 8'h11, 8'h06, 1'b0);
    bus.req = '0;

`ifdef SPI_ARB_TIMEOUT_EN
    timeout_run(1'b0);
    timeout_run(1'b1);
`else
    bus.req = 4'b0001;
    step();
    bus.req = '0;
    check("nto_gnt", 32'(bus.gnt), 1);
    step();
    check("nto_mstart", 32'(bus.m_start), 1);
    repeat (40) begin
      step();
      check("nto_busy", 32'(bus.busy), 1);
      check("nto_no_rsp", 32'(bus.rsp_valid), 0);
      check("nto_no_err", 32'(bus.timeout_err), 0);
    end
    bus.m_dout = 8'h5A;
    bus.m_done = 1'b1;
    step();
    bus.m_done = 1'b0;
    check("nto_rsp_valid", 32'(bus.rsp_valid), 1);
    check("nto_rsp_data", 32'(bus.rsp_data), 32'h5A);
    check("nto_err", 32'(bus.timeout_err), 0);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, giving the number of requesters sharing one spi_M (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 255, giving the maximum WAIT cycles before abort (1..65535).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  NREQ  per-requester transaction request (level).
REQ-006 SHALL have port req_data  input  8*NREQ  tx byte; requester i occupies bits [8i+7:8i].
REQ-007 SHALL have port gnt  output  NREQ  one-hot grant to the owning requester.
REQ-008 SHALL have port rsp_valid  output  NREQ  one-cycle response strobe to the owning requester.
REQ-009 SHALL have port rsp_data  output  8  rx byte; valid while any rsp_valid bit is high.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port m_start  output  1  one-cycle start pulse to spi_M.
REQ-012 SHALL have port m_din  output  8  tx byte to spi_M din.
REQ-013 SHALL have port m_dout  input  8  rx byte from spi_M dout.
REQ-014 SHALL have port m_done  input  1  transfer-complete from spi_M done.
REQ-015 SHALL have port timeout_err  output  1  one-cycle abort strobe.

Function
REQ-016 SHALL implement FSM states IDLE, START, WAIT, RESP, all outputs registered.
REQ-017 IDLE: when req is nonzero at a clock edge, SHALL select the winner, set gnt[winner], load m_din from req_data[winner] and go to START.
REQ-018 Winner SHALL be the first set req bit at or above round-robin pointer ptr, searching upward and wrapping at NREQ-1 to 0.
REQ-019 START: SHALL assert m_start for exactly one cycle, clear the wait counter, then go to WAIT.
REQ-020 WAIT: on m_done SHALL capture m_dout into rsp_data and go to RESP.
REQ-021 RESP: SHALL assert rsp_valid[winner] for one cycle, clear gnt, set ptr to (winner+1) mod NREQ, and return to IDLE.
REQ-022 Latency SHALL be 2 cycles from req sampled in IDLE to m_start high, and 1 cycle from m_done to rsp_valid.
REQ-023 gnt SHALL be high from START through WAIT and low in RESP and IDLE.
REQ-024 m_din SHALL stay stable from START until the next grant.
REQ-025 req changes after the grant SHALL be ignored; the transaction SHALL complete and rsp_valid SHALL still be issued.
REQ-026 m_done outside WAIT SHALL be ignored.
REQ-027 A requester holding req SHALL be re-arbitrated; back-to-back grants SHALL be separated by one IDLE cycle.
REQ-028 A single active requester SHALL be granted repeatedly regardless of ptr.

Reset
REQ-029 While rst is low, state SHALL be IDLE; gnt, rsp_valid, m_start and timeout_err SHALL be 0; rsp_data and m_din SHALL be 8'h00; ptr and the wait counter SHALL be 0; busy SHALL be 0.
REQ-030 Reset asserted mid-transaction SHALL abort it immediately with no rsp_valid; the first arbitration after reset SHALL start from ptr=0.

Configuration
REQ-031 Macro SPI_ARB_TIMEOUT_EN SHALL compile in the WAIT timeout.
REQ-032 With SPI_ARB_TIMEOUT_EN, a wait counter SHALL increment each WAIT cycle; on reaching TIMEOUT without m_done, the block SHALL set rsp_data=8'hFF, pulse timeout_err with rsp_valid[winner] in RESP, and proceed normally. m_done on the TIMEOUT cycle SHALL take priority, with no error.
REQ-033 Without SPI_ARB_TIMEOUT_EN, there SHALL be no counter, timeout_err SHALL be tied 0, and WAIT SHALL last indefinitely until m_done.

Verification
REQ-034 Reset, then req=4'b0001 with req_data[7:0]=8'hA5 -> m_start 2 cycles later with m_din=8'hA5; m_done with m_dout=8'h3C -> rsp_valid=4'b0001 and rsp_data=8'h3C on the next cycle.
REQ-035 req=4'b1111 held continuously -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
REQ-036 ptr=2 after a grant to requester 1, then req=4'b0011 -> requester 0 granted (wrap).
REQ-037 With SPI_ARB_TIMEOUT_EN and TIMEOUT=16, m_done never asserted -> after 16 WAIT cycles timeout_err=1, rsp_data=8'hFF, rsp_valid to the owner; m_done on cycle 16 -> no error.
REQ-038 rst low during WAIT -> all outputs 0 asynchronously, no rsp_valid, and the next grant goes to the lowest set req bit.
REQ-039 Owner drops req during WAIT and m_done arrives -> rsp_valid still issued to the owner; m_done pulses in IDLE -> no response.
